sram_tile_reader: RTL and testbench

- Read sequencer directly downstream of the 512x24 dual-port SRAM wrapper; drives port A read controls (address, read enable) and consumes port A read data.
- Walks a 2-D tile: i_NumRows rows of i_RowLen words, each row i_Stride words apart from the previous one.
- Delivers words to the systolic array feeder over a valid/ready stream, tagging the final word with o_Last.
- Absorbs the SRAM's fixed read latency with an internal credit-limited skid FIFO, so backpressure never drops a word.

---
 rtl/sram_tile_reader.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_sram_tile_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_tile_reader.sv
// -----------------------------------------------------------------------------
// sram_tile_reader
//
// Purpose:
//   Read sequencer sitting directly behind the 512x24 dual-port SRAM wrapper.
//   Walks a 2-D tile (i_NumRows rows of i_RowLen words, row starts i_Stride
//   words apart, addresses wrapping modulo 2^ADDR_W) in row-major order,
//   drives SRAM port A read controls, and delivers the returned words on a
//   valid/ready stream, tagging the final word with o_Last. A small
//   credit-limited skid FIFO absorbs the SRAM read latency so backpressure
//   never drops a word.
//
// Build option:
//   SRAM_RD_REG_EN - when defined, i_DataOut_A passes through an extra input
//                    register (read latency 2) and the FIFO depth / credit
//                    limit grow from 2 to 3 so full throughput is preserved.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RSTn         synchronous active-low reset
//   i_Start      one-cycle start strobe (only honoured in IDLE)
//   i_BaseAddr   address of tile word (0,0)
//   i_RowLen     words per row
//   i_NumRows    number of rows
//   i_Stride     address step between row starts
//   o_Addr_A     SRAM port A address (registered)
//   o_EN_R_A     SRAM port A read enable (registered, active high)
//   i_DataOut_A  SRAM port A read data
//   o_Data       stream data (FIFO head)
//   o_Valid      stream valid (FIFO not empty)
//   i_Ready      stream ready from consumer
//   o_Last       marks the final word of the tile
//   o_Busy       high while a tile is being issued/drained
//   o_Done       one-cycle pulse at tile completion
// -----------------------------------------------------------------------------
module sram_tile_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 24,
  parameter int CNT_W  = 9
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              i_Start,
  input  logic [ADDR_W-1:0] i_BaseAddr,
  input  logic [CNT_W-1:0]  i_RowLen,
  input  logic [CNT_W-1:0]  i_NumRows,
  input  logic [CNT_W-1:0]  i_Stride,
  output logic [ADDR_W-1:0] o_Addr_A,
  output logic              o_EN_R_A,
  input  logic [DATA_W-1:0] i_DataOut_A,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic              o_Last,
  output logic              o_Busy,
  output logic              o_Done
);

`ifdef SRAM_RD_REG_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif
  localparam int PTR_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched tile configuration
  logic [CNT_W-1:0]  row_len_q, row_len_d;
  logic [CNT_W-1:0]  num_rows_q, num_rows_d;
  logic [CNT_W-1:0]  stride_q, stride_d;

  // Walk position
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;

  // Registered SRAM controls plus the "final word" tag riding with the read
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              rd_last_q, rd_last_d;

`ifdef SRAM_RD_REG_EN
  // Second pipeline stage for the registered read-data path
  logic              en_p_q;
  logic              last_p_q;
  logic [DATA_W-1:0] rd_data_q;
`endif

  // Skid FIFO
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic              fifo_last_q [DEPTH];
  logic              fifo_last_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;

  logic              pop;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic              cap_last;
  logic [2:0]        inflight;
  logic [2:0]        credit_used;
  logic              can_issue;
  logic              issue;
  logic              is_last_col;
  logic              is_last_row;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  // ---------------------------------------------------------------------------
  // Capture path selection and credit accounting
  // ---------------------------------------------------------------------------
  always_comb begin
    pop = (count_q != '0) && i_Ready;
`ifdef SRAM_RD_REG_EN
    cap_valid = en_p_q;
    cap_data  = rd_data_q;
    cap_last  = last_p_q;
    inflight  = 3'(en_q) + 3'(en_p_q);
`else
    cap_valid = en_q;
    cap_data  = i_DataOut_A;
    cap_last  = rd_last_q;
    inflight  = 3'(en_q);
`endif
    // Words the FIFO must still hold once this cycle's pop has left; a new
    // read may only be issued if it would still fit.
    credit_used = 3'(count_q) - 3'(pop) + inflight;
    can_issue   = credit_used < 3'(DEPTH);
  end

  // ---------------------------------------------------------------------------
  // FSM next state and address generation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    stride_d   = stride_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    en_d       = 1'b0;
    rd_last_d  = 1'b0;

    is_last_col = (col_q == row_len_q - CNT_W'(1));
    is_last_row = (row_q == num_rows_q - CNT_W'(1));
    issue       = (state_q == S_ISSUE) && can_issue;

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          row_len_d  = i_RowLen;
          num_rows_d = i_NumRows;
          stride_d   = i_Stride;
          row_base_d = i_BaseAddr;
          col_d      = '0;
          row_d      = '0;
          if ((i_RowLen == '0) || (i_NumRows == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue && is_last_col && is_last_row) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Nothing left in the FIFO after this pop and nothing still returning
        if (credit_used == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      addr_d    = row_base_q + ADDR_W'(col_q);
      en_d      = 1'b1;
      rd_last_d = is_last_col && is_last_row;
      if (is_last_col) begin
        col_d      = '0;
        row_d      = row_q + CNT_W'(1);
        row_base_d = row_base_q + ADDR_W'(stride_q);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fifo_next
      always_comb begin
        fifo_data_d[gi] = fifo_data_q[gi];
        fifo_last_d[gi] = fifo_last_q[gi];
        if (cap_valid && (wr_ptr_q == PTR_W'(gi))) begin
          fifo_data_d[gi] = cap_data;
          fifo_last_d[gi] = cap_last;
        end
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (cap_valid) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + PTR_W'(cap_valid) - PTR_W'(pop);
  end

  // Head-of-FIFO mux
  always_comb begin
    head_data = '0;
    head_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == PTR_W'(i)) begin
        head_data = fifo_data_q[i];
        head_last = fifo_last_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      rd_last_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      rd_last_q  <= rd_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef SRAM_RD_REG_EN
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      en_p_q    <= 1'b0;
      last_p_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      en_p_q    <= en_q;
      last_p_q  <= rd_last_q;
      rd_data_q <= i_DataOut_A;
    end
  end
`endif

  // FIFO storage is cleared on reset so o_Data reads 0 out of reset
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fifo_reg
      always_ff @(posedge CLK) begin
        if (!RSTn) begin
          fifo_data_q[gi] <= '0;
          fifo_last_q[gi] <= 1'b0;
        end else begin
          fifo_data_q[gi] <= fifo_data_d[gi];
          fifo_last_q[gi] <= fifo_last_d[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_Addr_A = addr_q;
  assign o_EN_R_A = en_q;
  assign o_Valid  = (count_q != '0);
  assign o_Data   = head_data;
  assign o_Last   = o_Valid && head_last;
  assign o_Busy   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign o_Done   = (state_q == S_DONE);

endmodule

// File: tb/tb_sram_tile_reader.sv
// -----------------------------------------------------------------------------
// tb_sram_tile_reader
//
// Scoreboard bench for sram_tile_reader. Stimulus pushes the expected stream
// words (hand-computed tables) into a queue; an independent monitor pops and
// compares on every stream transfer, and also watches stall stability, the
// read credit bound and o_Done timing. The SRAM is modelled as SRAM[a] = a.
// -----------------------------------------------------------------------------
module tb_sram_tile_reader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 24;
  localparam int CNT_W  = 9;
`ifdef SRAM_RD_REG_EN
  localparam int LAT   = 3;
  localparam int DEPTH = 3;
`else
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
`endif

  logic              CLK;
  logic              RSTn;
  logic              i_Start;
  logic [ADDR_W-1:0] i_BaseAddr;
  logic [CNT_W-1:0]  i_RowLen;
  logic [CNT_W-1:0]  i_NumRows;
  logic [CNT_W-1:0]  i_Stride;
  logic [ADDR_W-1:0] o_Addr_A;
  logic              o_EN_R_A;
  logic [DATA_W-1:0] i_DataOut_A;
  logic [DATA_W-1:0] o_Data;
  logic              o_Valid;
  logic              i_Ready;
  logic              o_Last;
  logic              o_Busy;
  logic              o_Done;

  sram_tile_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .i_Start    (i_Start),
    .i_BaseAddr (i_BaseAddr),
    .i_RowLen   (i_RowLen),
    .i_NumRows  (i_NumRows),
    .i_Stride   (i_Stride),
    .o_Addr_A   (o_Addr_A),
    .o_EN_R_A   (o_EN_R_A),
    .i_DataOut_A(i_DataOut_A),
    .o_Data     (o_Data),
    .o_Valid    (o_Valid),
    .i_Ready    (i_Ready),
    .o_Last     (o_Last),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM contents: SRAM[a] = a
  assign i_DataOut_A = DATA_W'(o_Addr_A);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor-owned statistics
  int          en_total   = 0;
  int          vld_total  = 0;
  int          xfer_total = 0;
  int          issued     = 0;
  int          drained    = 0;
  logic        prev_stall = 1'b0;
  logic        prev_last_xfer = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  // Main-owned controls
  logic zero_mode = 1'b0;
  logic rmode     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Ready driver: constant 1, or pattern 1,0,0,1 followed by random
  // ---------------------------------------------------------------------------
  initial begin
    int pidx;
    logic [3:0] pat;
    pat  = 4'b1001;
    pidx = 0;
    i_Ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (rmode) begin
        if (pidx < 4) i_Ready = pat[3 - pidx];
        else          i_Ready = 1'($urandom_range(0, 1));
        pidx++;
      end else begin
        i_Ready = 1'b1;
        pidx    = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    exp_t e;
    logic cur_last_xfer;
    if (!RSTn) begin
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
      issued         = 0;
      drained        = 0;
    end else begin
      cur_last_xfer = 1'b0;
      if (o_EN_R_A) begin
        en_total++;
        issued++;
        check("credit_bound", 32'((issued - drained) <= DEPTH), 32'd1);
      end
      if (o_Valid) vld_total++;
      if (prev_stall) begin
        check("stall_valid", 32'(o_Valid), 32'd1);
        check("stall_data", 32'(o_Data), 32'(prev_data));
      end
      if (prev_last_xfer || o_Done) begin
        check("done_timing", 32'(o_Done), 32'(prev_last_xfer || zero_mode));
      end
      if (o_Valid && i_Ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", o_Data, $time);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(o_Data), 32'(e.data));
          check("last", 32'(o_Last), 32'(e.last));
          cur_last_xfer = e.last;
        end
        xfer_total++;
        drained++;
      end
      prev_last_xfer = cur_last_xfer;
      prev_stall     = o_Valid && !i_Ready;
      prev_data      = o_Data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push(input logic [DATA_W-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Returns one cycle after the accepting edge; scrambles the config inputs
  // afterwards so any late sampling would corrupt the tile.
  task automatic start_tile(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] rl,
                            input logic [CNT_W-1:0] nr, input logic [CNT_W-1:0] st);
    @(posedge CLK);
    #1;
    i_BaseAddr = base;
    i_RowLen   = rl;
    i_NumRows  = nr;
    i_Stride   = st;
    i_Start    = 1'b1;
    @(posedge CLK);
    #1;
    i_Start    = 1'b0;
    i_BaseAddr = 9'h0AA;
    i_RowLen   = 9'd3;
    i_NumRows  = 9'd7;
    i_Stride   = 9'd5;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!o_Done && k < 300) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check({name, "_done_seen"}, 32'(o_Done), 32'd1);
    @(posedge CLK);
    #1;
    check({name, "_done_pulse"}, 32'(o_Done), 32'd0);
    check({name, "_busy_low"}, 32'(o_Busy), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_tile1();
    logic [DATA_W-1:0] t1 [8];
    t1 = '{24'h010, 24'h011, 24'h012, 24'h013, 24'h018, 24'h019, 24'h01A, 24'h01B};
    for (int i = 0; i < 8; i++) push(t1[i], i == 7);
  endtask

  task automatic push_tile16();
    logic [DATA_W-1:0] t16 [16];
    // Base 0x1FC, RowLen 8, NumRows 2, Stride 0x40: row 0 wraps past 0x1FF
    t16 = '{24'h1FC, 24'h1FD, 24'h1FE, 24'h1FF, 24'h000, 24'h001, 24'h002, 24'h003,
            24'h03C, 24'h03D, 24'h03E, 24'h03F, 24'h040, 24'h041, 24'h042, 24'h043};
    for (int i = 0; i < 16; i++) push(t16[i], i == 15);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int snap_en;
    int snap_vld;
    int snap_x;
    RSTn       = 1'b0;
    i_Start    = 1'b0;
    i_BaseAddr = '0;
    i_RowLen   = '0;
    i_NumRows  = '0;
    i_Stride   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_outputs", {o_Addr_A, o_EN_R_A, o_Valid, o_Last, o_Busy, o_Done},
          32'd0);
    check("rst_data", 32'(o_Data), 32'd0);
    RSTn = 1'b1;

    // Tile 1: full throughput, latency and done timing
    push_tile1();
    start_tile(9'h010, 9'd4, 9'd2, 9'd8);
    check("t1_busy", 32'(o_Busy), 32'd1);
    k = 0;
    while (!o_Valid && k < 20) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check("t1_first_valid_lat", 32'(k), 32'(LAT));
    k = 0;
    while (o_Valid && k < 20) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check("t1_consecutive_valid", 32'(k), 32'd8);
    check("t1_done_after_last", 32'(o_Done), 32'd1);
    check("t1_busy_falls", 32'(o_Busy), 32'd0);
    wait_done("t1");
    $display("tile1 base=0x010 len=4 rows=2 stride=8 done, checks=%0d errors=%0d", checks, errors);

    // Tile 2: address wrap 0x1FE..0x001
    push(24'h1FE, 1'b0);
    push(24'h1FF, 1'b0);
    push(24'h000, 1'b0);
    push(24'h001, 1'b1);
    start_tile(9'h1FE, 9'd4, 9'd1, 9'd0);
    wait_done("t2");
    $display("tile2 wrap base=0x1FE len=4 rows=1 done, checks=%0d errors=%0d", checks, errors);

    // Tile 3: tile 1 under random backpressure
    rmode = 1'b1;
    push_tile1();
    start_tile(9'h010, 9'd4, 9'd2, 9'd8);
    wait_done("t3");
    rmode = 1'b0;
    $display("tile3 backpressure done, checks=%0d errors=%0d", checks, errors);

    // Tile 4: zero row length
    zero_mode = 1'b1;
    snap_en   = en_total;
    snap_vld  = vld_total;
    start_tile(9'h020, 9'd0, 9'd5, 9'd1);
    check("t4_done_pulse", 32'(o_Done), 32'd1);
    check("t4_busy", 32'(o_Busy), 32'd0);
    @(posedge CLK);
    #1;
    check("t4_done_single", 32'(o_Done), 32'd0);
    repeat (5) @(posedge CLK);
    #1;
    zero_mode = 1'b0;
    check("t4_no_reads", 32'(en_total - snap_en), 32'd0);
    check("t4_no_valid", 32'(vld_total - snap_vld), 32'd0);
    $display("tile4 zero-length done, checks=%0d errors=%0d", checks, errors);

    // Tile 5: reset after the 3rd transfer of a 16-word tile, then rerun
    push_tile16();
    snap_x = xfer_total;
    start_tile(9'h1FC, 9'd8, 9'd2, 9'h040);
    k = 0;
    while ((xfer_total - snap_x) < 3 && k < 100) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check("t5_three_xfers", 32'(xfer_total - snap_x), 32'd3);
    RSTn = 1'b0;
    exp_q.delete();
    @(posedge CLK);
    #1;
    check("t5_rst_outputs", {o_Addr_A, o_EN_R_A, o_Valid, o_Last, o_Busy, o_Done},
          32'd0);
    check("t5_rst_data", 32'(o_Data), 32'd0);
    RSTn = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      #1;
      if (o_Done) k++;
    end
    check("t5_no_done_after_abort", 32'(k), 32'd0);
    push_tile16();
    start_tile(9'h1FC, 9'd8, 9'd2, 9'h040);
    wait_done("t5");
    $display("tile5 reset-abort and rerun done, checks=%0d errors=%0d", checks, errors);

    // Tile 6: second start mid-tile is ignored
    push_tile1();
    start_tile(9'h010, 9'd4, 9'd2, 9'd8);
    @(posedge CLK);
    #1;
    i_BaseAddr = 9'h100;
    i_RowLen   = 9'd2;
    i_NumRows  = 9'd2;
    i_Stride   = 9'd1;
    i_Start    = 1'b1;
    @(posedge CLK);
    #1;
    i_Start = 1'b0;
    wait_done("t6");
    repeat (4) @(posedge CLK);
    #1;
    check("t6_idle_after", 32'(o_Busy), 32'd0);
    $display("tile6 ignored restart done, checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
